// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//   Debounces NUM_BTN raw push-button inputs using a slow sampling clock.
//   tick_clk (for example 100 Hz from an upstream divider) is handled as data.
//   It is synchronised into the clk_in domain and edge-detected into a
//   one-cycle sample_tick. On each sample_tick, every channel's synchronised
//   level is fed to a small FSM. A change is accepted only after
//   STABLE_SAMPLES consecutive equal samples.
//
// Ports
//   clk_in       in   1        system clock, sole clock of the block
//   rst          in   1        synchronous, active-high reset
//   tick_clk     in   1        divided sampling clock, treated as data
//   btn_raw      in   NUM_BTN  asynchronous raw button pins
//   sample_tick  out  1        one clk_in pulse per tick_clk rising edge
//   btn_level    out  NUM_BTN  debounced level, 1 = pressed
//   btn_press    out  NUM_BTN  one-cycle pulse on accepted press
//   btn_release  out  NUM_BTN  one-cycle pulse on accepted release
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int unsigned NUM_BTN        = 4,
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               tick_clk,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               sample_tick,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int unsigned CW = $clog2(STABLE_SAMPLES + 1);

    // "cnt + 1 == STABLE_SAMPLES" is evaluated as "cnt == STABLE_SAMPLES - 1".
    // This keeps the comparison at the counter's own width.
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // tick_clk synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    logic t1;
    logic t2;
    logic t3;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            t1          <= 1'b0;
            t2          <= 1'b0;
            t3          <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            t1          <= tick_clk;
            t2          <= t1;
            t3          <= t2;
            sample_tick <= t2 & ~t3;
        end
    end

    // ------------------------------------------------------------------
    // Button polarity normalisation and 2-FF synchroniser (1 = pressed)
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_norm;
    logic [NUM_BTN-1:0] btn_m;
    logic [NUM_BTN-1:0] btn_s;

    always_comb begin
        btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            btn_m <= '0;
            btn_s <= '0;
        end else begin
            btn_m <= btn_norm;
            btn_s <= btn_m;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce FSM
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          press_nxt;
        logic          release_nxt;
        logic          level_nxt;
        logic          level_q;
        logic          press_q;
        logic          release_q;

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;

            if (sample_tick) begin
                case (state)
                    S_LOW: begin
                        if (btn_s[g]) begin
                            state_nxt = S_RISE;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                    S_RISE: begin
                        if (!btn_s[g]) begin
                            state_nxt = S_LOW;
                            cnt_nxt   = '0;
                        end else if (cnt == CNT_LAST) begin
                            state_nxt = S_HIGH;
                            cnt_nxt   = '0;
                            press_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
                    S_HIGH: begin
                        if (!btn_s[g]) begin
                            state_nxt = S_FALL;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                    S_FALL: begin
                        if (btn_s[g]) begin
                            state_nxt = S_HIGH;
                            cnt_nxt   = '0;
                        end else if (cnt == CNT_LAST) begin
                            state_nxt   = S_LOW;
                            cnt_nxt     = '0;
                            release_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state_nxt = S_LOW;
                        cnt_nxt   = '0;
                    end
                endcase
            end

            // The level follows the next state, so it changes on the same
            // edge as the corresponding press/release pulse.
            level_nxt = (state_nxt == S_HIGH) || (state_nxt == S_FALL);
        end

        always_ff @(posedge clk_in) begin
            if (rst) begin
                state     <= S_LOW;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
    end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    logic       clk_in;
    logic       rst;
    logic       tick_clk;
    logic       tick_en;
    logic [1:0] btn_raw;
    logic       sample_tick;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;

    button_debouncer #(
        .NUM_BTN       (2),
        .STABLE_SAMPLES(4),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .tick_clk   (tick_clk),
        .btn_raw    (btn_raw),
        .sample_tick(sample_tick),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // clk_in has a 10 ns period. tick_clk has a 200 ns period (20 clk_in
    // cycles), and its edges are offset from the clk_in edges.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        tick_clk = 1'b0;
        #3;
        forever begin
            #100;
            if (tick_en) tick_clk = ~tick_clk;
        end
    end

    typedef struct {
        logic [1:0]  press;
        logic [1:0]  rel;
        logic [1:0]  lvl;
        int unsigned tick;
    } ev_t;

    ev_t         obs_q[$];
    ev_t         exp_q[$];
    int unsigned tick_cnt     = 0;
    int unsigned cyc          = 0;
    int unsigned last_tick_cyc = 0;
    int          n_checks     = 0;
    int          n_fail       = 0;

    // Monitor: counts sample ticks and logs every pulse with the tick count.
    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (sample_tick === 1'b1) begin
            tick_cnt      = tick_cnt + 1;
            last_tick_cyc = cyc;
        end
        if (btn_press != 2'b00 || btn_release != 2'b00)
            obs_q.push_back('{btn_press, btn_release, btn_level, tick_cnt});
    end

    task automatic wait_tick();
        int unsigned start;
        start = tick_cnt;
        n_checks++;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            #1;
            if (tick_cnt != start) return;
        end
        n_fail++;
        $display("FAIL wait_tick: ticks=%0d, required %0d within 40 cycles", tick_cnt, start + 1);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic test_reset();
        int unsigned c1;
        int unsigned c2;
        rst     = 1'b1;
        btn_raw = 2'b11;
        repeat (5) @(negedge clk_in);
        n_checks++;
        if (sample_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b, expected 0", sample_tick);
        end
        n_checks++;
        if (btn_level !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_level: got %b, expected 00", btn_level);
        end
        n_checks++;
        if (btn_press !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_press: got %b, expected 00", btn_press);
        end
        n_checks++;
        if (btn_release !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got %b, expected 00", btn_release);
        end
        rst = 1'b0;
        wait_tick();
        wait_tick();
        c1 = last_tick_cyc;
        @(negedge clk_in);
        #1;
        n_checks++;
        if (sample_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_width: got %b one cycle after tick, expected 0", sample_tick);
        end
        wait_tick();
        c2 = last_tick_cyc;
        n_checks++;
        if (c2 - c1 !== 20) begin
            n_fail++;
            $display("FAIL tick_period: got %0d cycles, expected 20", c2 - c1);
        end
        n_checks++;
        if (btn_level !== 2'b00 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle: level %b pulses %0d, expected 00 and 0", btn_level, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_single_press();
        int unsigned base;
        ev_t o;
        ev_t e;
        wait_tick();
        base       = tick_cnt;
        btn_raw[0] = 1'b0;
        exp_q.push_back('{2'b01, 2'b00, 2'b01, base + 4});
        wait_ticks(5);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL press_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.press !== e.press || o.rel !== e.rel || o.lvl !== e.lvl || o.tick !== e.tick) begin
                n_fail++;
                $display("FAIL press_event: got p=%b r=%b l=%b t=%0d, expected p=%b r=%b l=%b t=%0d",
                         o.press, o.rel, o.lvl, o.tick, e.press, e.rel, e.lvl, e.tick);
            end
        end
        obs_q.delete();
        exp_q.delete();
        n_checks++;
        if (btn_level !== 2'b01) begin
            n_fail++;
            $display("FAIL press_level: got %b, expected 01", btn_level);
        end
    endtask

    task automatic test_release();
        int unsigned base;
        ev_t o;
        ev_t e;
        wait_tick();
        base       = tick_cnt;
        btn_raw[0] = 1'b1;
        exp_q.push_back('{2'b00, 2'b01, 2'b00, base + 4});
        wait_ticks(5);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL release_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.press !== e.press || o.rel !== e.rel || o.lvl !== e.lvl || o.tick !== e.tick) begin
                n_fail++;
                $display("FAIL release_event: got p=%b r=%b l=%b t=%0d, expected p=%b r=%b l=%b t=%0d",
                         o.press, o.rel, o.lvl, o.tick, e.press, e.rel, e.lvl, e.tick);
            end
        end
        obs_q.delete();
        exp_q.delete();
        n_checks++;
        if (btn_level !== 2'b00) begin
            n_fail++;
            $display("FAIL release_level: got %b, expected 00", btn_level);
        end
    endtask

    task automatic test_bounce();
        int unsigned base;
        ev_t o;
        ev_t e;
        wait_tick();
        base       = tick_cnt;
        btn_raw[0] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            wait_ticks(3);
            btn_raw[0] = 1'b1;
            wait_tick();
            btn_raw[0] = 1'b0;
        end
        // 12 ticks of bounce, then 4 clean low samples.
        exp_q.push_back('{2'b01, 2'b00, 2'b01, base + 16});
        wait_ticks(5);
        base       = tick_cnt;
        btn_raw[0] = 1'b1;
        exp_q.push_back('{2'b00, 2'b01, 2'b00, base + 4});
        wait_ticks(5);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bounce_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.press !== e.press || o.rel !== e.rel || o.lvl !== e.lvl || o.tick !== e.tick) begin
                n_fail++;
                $display("FAIL bounce_event: got p=%b r=%b l=%b t=%0d, expected p=%b r=%b l=%b t=%0d",
                         o.press, o.rel, o.lvl, o.tick, e.press, e.rel, e.lvl, e.tick);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        int unsigned base;
        ev_t o;
        ev_t e;
        wait_tick();
        base    = tick_cnt;
        btn_raw = 2'b00;
        exp_q.push_back('{2'b11, 2'b00, 2'b11, base + 4});
        wait_ticks(5);
        n_checks++;
        if (btn_level !== 2'b11) begin
            n_fail++;
            $display("FAIL simul_level: got %b, expected 11", btn_level);
        end
        base    = tick_cnt;
        btn_raw = 2'b11;
        exp_q.push_back('{2'b00, 2'b11, 2'b00, base + 4});
        wait_ticks(5);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL simul_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.press !== e.press || o.rel !== e.rel || o.lvl !== e.lvl || o.tick !== e.tick) begin
                n_fail++;
                $display("FAIL simul_event: got p=%b r=%b l=%b t=%0d, expected p=%b r=%b l=%b t=%0d",
                         o.press, o.rel, o.lvl, o.tick, e.press, e.rel, e.lvl, e.tick);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_press();
        int unsigned base;
        ev_t o;
        ev_t e;
        wait_tick();
        base       = tick_cnt;
        btn_raw[0] = 1'b0;
        exp_q.push_back('{2'b01, 2'b00, 2'b01, base + 4});
        wait_ticks(5);
        n_checks++;
        if (btn_level !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_pre_level: got %b, expected 01", btn_level);
        end
        repeat (5) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if (btn_level !== 2'b00 || btn_release !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_clear: got level %b release %b, expected 00 00", btn_level, btn_release);
        end
        rst  = 1'b0;
        base = tick_cnt;
        exp_q.push_back('{2'b01, 2'b00, 2'b01, base + 4});
        wait_ticks(5);
        base       = tick_cnt;
        btn_raw[0] = 1'b1;
        exp_q.push_back('{2'b00, 2'b01, 2'b00, base + 4});
        wait_ticks(5);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.press !== e.press || o.rel !== e.rel || o.lvl !== e.lvl || o.tick !== e.tick) begin
                n_fail++;
                $display("FAIL midrst_event: got p=%b r=%b l=%b t=%0d, expected p=%b r=%b l=%b t=%0d",
                         o.press, o.rel, o.lvl, o.tick, e.press, e.rel, e.lvl, e.tick);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_tick_stopped();
        int unsigned t0;
        wait_tick();
        tick_en = 1'b0;
        t0      = tick_cnt;
        btn_raw = 2'b01;
        repeat (200) @(negedge clk_in);
        #1;
        n_checks++;
        if (tick_cnt != t0) begin
            n_fail++;
            $display("FAIL frozen_ticks: got %0d ticks, expected %0d", tick_cnt, t0);
        end
        n_checks++;
        if (btn_level !== 2'b00 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL frozen_out: level %b pulses %0d, expected 00 and 0", btn_level, obs_q.size());
        end
        btn_raw = 2'b11;
        repeat (10) @(negedge clk_in);
        tick_en = 1'b1;
        wait_ticks(5);
        n_checks++;
        if (btn_level !== 2'b00 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL resumed_out: level %b pulses %0d, expected 00 and 0", btn_level, obs_q.size());
        end
        obs_q.delete();
    endtask

    initial begin
        rst     = 1'b1;
        tick_en = 1'b1;
        btn_raw = 2'b11;
        test_reset();
        test_single_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid_press();
        test_tick_stopped();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
